// File: rtl/mem_stage_if.sv
// Data-memory request/grant/response port between the memory stage (master) and data memory.
interface mem_stage_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                    req;
   logic                    we;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH/8-1:0] be;
   logic [DATA_WIDTH-1:0]   wdata;
   logic                    gnt;
   logic                    rvalid;
   logic [DATA_WIDTH-1:0]   rdata;

   modport master (
      output req, we, addr, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory-access stage: passes ALU ops straight to WB, runs loads/stores on the
// req/gnt/rvalid port and stalls upstream until each access completes.
module mem_stage #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  MEM_valid_i,
   input  logic [4:0]            MEM_rd_add_i,
   input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
   input  logic [DATA_WIDTH-1:0] MEM_store_data_i,
   input  logic                  MEM_memread_i,
   input  logic                  MEM_memwrite_i,
   input  logic [2:0]            MEM_funct3_i,
   input  logic [1:0]            MEM_sel_to_reg_i,
   input  logic                  MEM_regwrite_i,
   input  logic [DATA_WIDTH-1:0] MEM_pc_i,
   input  logic [DATA_WIDTH-1:0] MEM_imm_i,
   output logic                  MEM_stall_o,
   output logic                  MEM_misalign_o,
   mem_stage_if.master           dmem,
   output logic [4:0]            WB_rd_add_o,
   output logic [DATA_WIDTH-1:0] WB_alu_result_o,
   output logic [1:0]            WB_sel_to_reg_o,
   output logic                  WB_regwrite_o,
   output logic [DATA_WIDTH-1:0] WB_pc_o,
   output logic [DATA_WIDTH-1:0] WB_imm_o,
   output logic [DATA_WIDTH-1:0] DMEM_data_o
);

   typedef enum logic [1:0] {StIdle, StReq, StWaitR} state_e;

   state_e                state_q;
   logic [4:0]            rd_q;
   logic [DATA_WIDTH-1:0] alu_q;
   logic [DATA_WIDTH-1:0] sd_q;
   logic [2:0]            f3_q;
   logic [1:0]            sel_q;
   logic                  rw_q;
   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] imm_q;
   logic                  memread_q;
   logic                  memwrite_q;
   logic [DATA_WIDTH-1:0] dmem_data_q;

   logic                  mem_op;
   logic                  misaligned;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_WIDTH-1:0] ld_data;

   // Size comes from funct3[1:0]: 00 byte, 01 half, anything else word.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return off[0];
         default: return |off;
      endcase
   endfunction

   assign mem_op     = MEM_valid_i & (MEM_memread_i | MEM_memwrite_i);
   assign misaligned = is_misaligned(MEM_funct3_i[1:0], MEM_alu_result_i[1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rd_q        <= '0;
         alu_q       <= '0;
         sd_q        <= '0;
         f3_q        <= '0;
         sel_q       <= '0;
         rw_q        <= 1'b0;
         pc_q        <= '0;
         imm_q       <= '0;
         memread_q   <= 1'b0;
         memwrite_q  <= 1'b0;
         dmem_data_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (mem_op && !misaligned) begin
                  rd_q       <= MEM_rd_add_i;
                  alu_q      <= MEM_alu_result_i;
                  sd_q       <= MEM_store_data_i;
                  f3_q       <= MEM_funct3_i;
                  sel_q      <= MEM_sel_to_reg_i;
                  rw_q       <= MEM_regwrite_i;
                  pc_q       <= MEM_pc_i;
                  imm_q      <= MEM_imm_i;
                  memread_q  <= MEM_memread_i;
                  memwrite_q <= MEM_memwrite_i;
                  state_q    <= StReq;
               end
            end
            StReq: begin
               if (dmem.gnt) begin
                  state_q <= (memread_q && !memwrite_q) ? StWaitR : StIdle;
               end
            end
            StWaitR: begin
               if (dmem.rvalid) begin
                  dmem_data_q <= ld_data;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign MEM_stall_o    = (state_q != StIdle);
   assign MEM_misalign_o = (state_q == StIdle) & mem_op & misaligned;
   assign DMEM_data_o    = dmem_data_q;

   assign dmem.req  = (state_q == StReq);
   assign dmem.we   = dmem.req & memwrite_q;
   assign dmem.addr = {alu_q[ADDR_WIDTH-1:2], 2'b00};

   always_comb begin
      dmem.be    = '0;
      dmem.wdata = sd_q;
      case (f3_q[1:0])
         2'b00: begin
            dmem.be    = 4'b0001 << alu_q[1:0];
            dmem.wdata = {4{sd_q[7:0]}};
         end
         2'b01: begin
            dmem.be    = alu_q[1] ? 4'b1100 : 4'b0011;
            dmem.wdata = {2{sd_q[15:0]}};
         end
         default: dmem.be = 4'b1111;
      endcase
      if (!dmem.req) dmem.be = '0;
   end

   always_comb begin
      ld_byte = dmem.rdata[7:0];
      case (alu_q[1:0])
         2'd0:    ld_byte = dmem.rdata[7:0];
         2'd1:    ld_byte = dmem.rdata[15:8];
         2'd2:    ld_byte = dmem.rdata[23:16];
         default: ld_byte = dmem.rdata[31:24];
      endcase
      ld_half = alu_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
      case (f3_q)
         3'b000:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
         3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
         3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
         default: ld_data = dmem.rdata;
      endcase
   end

   // Memory ops bubble WB on entry; the held instruction reaches WB on completion.
   always_comb begin
      if (state_q == StIdle) begin
         WB_rd_add_o     = MEM_rd_add_i;
         WB_alu_result_o = MEM_alu_result_i;
         WB_sel_to_reg_o = MEM_sel_to_reg_i;
         WB_pc_o         = MEM_pc_i;
         WB_imm_o        = MEM_imm_i;
         WB_regwrite_o   = MEM_valid_i & MEM_regwrite_i & ~(MEM_memread_i | MEM_memwrite_i);
      end else begin
         WB_rd_add_o     = rd_q;
         WB_alu_result_o = alu_q;
         WB_sel_to_reg_o = sel_q;
         WB_pc_o         = pc_q;
         WB_imm_o        = imm_q;
         WB_regwrite_o   = (state_q == StWaitR) & dmem.rvalid & rw_q;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage with a behavioural load/store reference model.
module tb_mem_stage;

   logic        clk;
   logic        rst_n;
   logic        MEM_valid_i;
   logic [4:0]  MEM_rd_add_i;
   logic [31:0] MEM_alu_result_i;
   logic [31:0] MEM_store_data_i;
   logic        MEM_memread_i;
   logic        MEM_memwrite_i;
   logic [2:0]  MEM_funct3_i;
   logic [1:0]  MEM_sel_to_reg_i;
   logic        MEM_regwrite_i;
   logic [31:0] MEM_pc_i;
   logic [31:0] MEM_imm_i;
   logic        MEM_stall_o;
   logic        MEM_misalign_o;
   logic [4:0]  WB_rd_add_o;
   logic [31:0] WB_alu_result_o;
   logic [1:0]  WB_sel_to_reg_o;
   logic        WB_regwrite_o;
   logic [31:0] WB_pc_o;
   logic [31:0] WB_imm_o;
   logic [31:0] DMEM_data_o;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          last_done = 0;
   logic [31:0] exp_dmem = 32'h0;

   mem_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dmem ();

   mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .MEM_valid_i      (MEM_valid_i),
      .MEM_rd_add_i     (MEM_rd_add_i),
      .MEM_alu_result_i (MEM_alu_result_i),
      .MEM_store_data_i (MEM_store_data_i),
      .MEM_memread_i    (MEM_memread_i),
      .MEM_memwrite_i   (MEM_memwrite_i),
      .MEM_funct3_i     (MEM_funct3_i),
      .MEM_sel_to_reg_i (MEM_sel_to_reg_i),
      .MEM_regwrite_i   (MEM_regwrite_i),
      .MEM_pc_i         (MEM_pc_i),
      .MEM_imm_i        (MEM_imm_i),
      .MEM_stall_o      (MEM_stall_o),
      .MEM_misalign_o   (MEM_misalign_o),
      .dmem             (dmem),
      .WB_rd_add_o      (WB_rd_add_o),
      .WB_alu_result_o  (WB_alu_result_o),
      .WB_sel_to_reg_o  (WB_sel_to_reg_o),
      .WB_regwrite_o    (WB_regwrite_o),
      .WB_pc_o          (WB_pc_o),
      .WB_imm_o         (WB_imm_o),
      .DMEM_data_o      (DMEM_data_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk1(input string name, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0b expected=%0b", name, obs, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         default:    return 4;
      endcase
   endfunction

   function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      logic [31:0] v;
      int          sz;
      logic        sgn;
      sz  = size_of(f3);
      sgn = (f3 == 3'd0) || (f3 == 3'd1);
      v   = rdata >> (8 * (addr % 4));
      if (sz == 1) begin
         v = v % 256;
         if (sgn && v >= 128) v = v - 256;
      end else if (sz == 2) begin
         v = v % 65536;
         if (sgn && v >= 32768) v = v - 65536;
      end
      return v;
   endfunction

   function automatic logic [31:0] be_model(input int sz, input logic [31:0] addr);
      if (sz == 1) return 32'd1 << (addr % 4);
      if (sz == 2) return 32'd3 << (addr % 4);
      return 32'd15;
   endfunction

   function automatic logic [31:0] wdata_model(input int sz, input logic [31:0] sd);
      if (sz == 1) return (sd % 256) * 32'h0101_0101;
      if (sz == 2) return (sd % 65536) * 32'h0001_0001;
      return sd;
   endfunction

   // One instruction through the stage; gw/rw are the gnt and rvalid wait-cycle counts.
   task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                        input int gw, input int rw);
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] exp_ld;
      int          sz;
      logic        mem;
      logic        mis;
      rd     = 5'($urandom);
      pc     = $urandom;
      imm    = $urandom;
      sz     = size_of(f3);
      mem    = ld | st;
      mis    = mem && ((addr % sz) != 0);
      exp_ld = load_model(f3, addr, rdata);

      @(negedge clk);
      MEM_valid_i      = 1'b1;
      MEM_rd_add_i     = rd;
      MEM_alu_result_i = addr;
      MEM_store_data_i = sd;
      MEM_memread_i    = ld;
      MEM_memwrite_i   = st;
      MEM_funct3_i     = f3;
      MEM_sel_to_reg_i = ld ? 2'b10 : 2'b01;
      MEM_regwrite_i   = ~st;
      MEM_pc_i         = pc;
      MEM_imm_i        = imm;
      dmem.gnt         = 1'b0;
      dmem.rvalid      = 1'b0;
      #1;
      chk1("entry_stall", MEM_stall_o, 1'b0);
      chk1("entry_req", dmem.req, 1'b0);
      chk1("entry_misalign", MEM_misalign_o, mis);
      chk1("entry_regwrite", WB_regwrite_o, !mem);
      chk32("entry_alu", WB_alu_result_o, addr);
      chk32("entry_pc", WB_pc_o, pc);
      last_done = cyc;
      if (!mem || mis) return;

      for (int i = 0; i <= gw; i++) begin
         @(negedge clk);
         if (i == 0) begin
            // Upstream has advanced; the next instruction must be held off.
            MEM_memread_i    = 1'b1;
            MEM_memwrite_i   = 1'b0;
            MEM_alu_result_i = $urandom;
            MEM_rd_add_i     = 5'($urandom);
         end
         dmem.gnt = (i == gw);
         #1;
         chk1("req_req", dmem.req, 1'b1);
         chk1("req_stall", MEM_stall_o, 1'b1);
         chk1("req_we", dmem.we, st);
         chk32("req_addr", dmem.addr, addr - (addr % 4));
         chk1("req_regwrite", WB_regwrite_o, 1'b0);
         chk32("req_rd", 32'(WB_rd_add_o), 32'(rd));
         if (st) begin
            chk32("req_be", 32'(dmem.be), be_model(sz, addr));
            chk32("req_wdata", dmem.wdata, wdata_model(sz, sd));
         end
      end
      last_done = cyc;

      if (ld) begin
         for (int j = 0; j <= rw; j++) begin
            @(negedge clk);
            dmem.gnt    = 1'b0;
            dmem.rvalid = (j == rw);
            dmem.rdata  = (j == rw) ? rdata : $urandom;
            #1;
            chk1("wait_req", dmem.req, 1'b0);
            chk1("wait_stall", MEM_stall_o, 1'b1);
            chk1("wait_regwrite", WB_regwrite_o, j == rw);
            chk32("wait_rd", 32'(WB_rd_add_o), 32'(rd));
            chk32("wait_sel", 32'(WB_sel_to_reg_o), 32'd2);
            chk32("wait_data_hold", DMEM_data_o, exp_dmem);
         end
         exp_dmem  = exp_ld;
         last_done = cyc;
      end

      @(posedge clk);
      #1;
      chk1("after_stall", MEM_stall_o, 1'b0);
      chk1("after_req", dmem.req, 1'b0);
      chk32("after_data", DMEM_data_o, exp_dmem);
   endtask

   initial begin
      logic [2:0]  ld_f3s [8];
      logic [2:0]  st_f3s [3];
      logic [31:0] a;
      int          d1;
      int          k;
      ld_f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      st_f3s = '{3'd0, 3'd1, 3'd2};

      rst_n            = 1'b0;
      MEM_valid_i      = 1'b0;
      MEM_rd_add_i     = '0;
      MEM_alu_result_i = '0;
      MEM_store_data_i = '0;
      MEM_memread_i    = 1'b0;
      MEM_memwrite_i   = 1'b0;
      MEM_funct3_i     = '0;
      MEM_sel_to_reg_i = '0;
      MEM_regwrite_i   = 1'b0;
      MEM_pc_i         = '0;
      MEM_imm_i        = '0;
      dmem.gnt         = 1'b0;
      dmem.rvalid      = 1'b0;
      dmem.rdata       = '0;

      repeat (2) @(negedge clk);
      #1;
      chk1("rst_stall", MEM_stall_o, 1'b0);
      chk1("rst_req", dmem.req, 1'b0);
      chk1("rst_we", dmem.we, 1'b0);
      chk32("rst_data", DMEM_data_o, 32'h0);
      chk1("rst_regwrite", WB_regwrite_o, 1'b0);
      chk1("rst_misalign", MEM_misalign_o, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset while waiting for read data; the late rvalid must be ignored.
      @(negedge clk);
      MEM_valid_i      = 1'b1;
      MEM_memread_i    = 1'b1;
      MEM_regwrite_i   = 1'b1;
      MEM_funct3_i     = 3'd2;
      MEM_alu_result_i = 32'h40;
      @(negedge clk);
      MEM_valid_i = 1'b0;
      dmem.gnt    = 1'b1;
      @(negedge clk);
      dmem.gnt = 1'b0;
      #1;
      chk1("rstw_stall_before", MEM_stall_o, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("rstw_stall", MEM_stall_o, 1'b0);
      chk1("rstw_req", dmem.req, 1'b0);
      @(negedge clk);
      rst_n       = 1'b1;
      dmem.rvalid = 1'b1;
      dmem.rdata  = 32'hFFFF_FFFF;
      #1;
      chk1("rstw_regwrite", WB_regwrite_o, 1'b0);
      @(posedge clk);
      #1;
      chk32("rstw_data", DMEM_data_o, 32'h0);
      chk1("rstw_stall_after", MEM_stall_o, 1'b0);
      chk1("rstw_req_after", dmem.req, 1'b0);
      @(negedge clk);
      dmem.rvalid = 1'b0;

      // Directed cases
      do_op(1'b0, 1'b0, 3'd0, 32'h10, 32'h0, 32'h0, 0, 0);
      do_op(1'b0, 1'b1, 3'd0, 32'h103, 32'hAB, 32'h0, 2, 0);
      do_op(1'b1, 1'b0, 3'd0, 32'h102, 32'h0, 32'h0080_0000, 0, 2);
      chk32("lb_value", DMEM_data_o, 32'hFFFF_FF80);
      do_op(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 32'h8001_0000, 0, 0);
      chk32("lhu_value", DMEM_data_o, 32'h0000_8001);
      do_op(1'b1, 1'b0, 3'd2, 32'h106, 32'h0, 32'h1234_5678, 0, 0);
      chk32("misalign_data_kept", DMEM_data_o, 32'h0000_8001);
      do_op(1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 32'h1111_2222, 0, 0);
      d1 = last_done;
      do_op(1'b1, 1'b0, 3'd2, 32'h204, 32'h0, 32'h3333_4444, 0, 0);
      chk32("b2b_spacing", 32'(last_done - d1), 32'd3);
      chk32("b2b_second", DMEM_data_o, 32'h3333_4444);

      // Randomized mix against the reference model
      for (int n = 0; n < 80; n++) begin
         k = $urandom_range(0, 2);
         a = $urandom;
         if (k == 0) begin
            do_op(1'b0, 1'b0, 3'($urandom), a, $urandom, 32'h0, 0, 0);
         end else if (k == 1) begin
            do_op(1'b1, 1'b0, ld_f3s[$urandom_range(0, 7)], a, 32'h0, $urandom,
                  $urandom_range(0, 2), $urandom_range(0, 2));
         end else begin
            do_op(1'b0, 1'b1, st_f3s[$urandom_range(0, 2)], a, $urandom, 32'h0,
                  $urandom_range(0, 2), 0);
         end
      end

      @(negedge clk);
      MEM_valid_i = 1'b0;
      dmem.gnt    = 1'b0;
      dmem.rvalid = 1'b0;
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
